// File: rtl/tcp_flowid_manager_if.sv
// ---------------------------------------------------------------------------
// tcp_flowid_manager_if
//
// Groups the allocate and release handshakes of the flow-ID free list.
//
// Handshake semantics (both channels):
//   Allocate: the manager drives flowid_avail/flowid_out; the requester drives
//     flowid_manager_req. An ID is transferred on a rising edge where
//     flowid_manager_req && flowid_avail. flowid_avail and flowid_out never
//     depend on flowid_manager_req, so req may be held high for
//     back-to-back grants.
//   Release: the teardown logic drives flowid_ret_val/flowid_ret_id; the
//     manager drives flowid_ret_rdy. The release is consumed on a rising edge
//     where flowid_ret_val && flowid_ret_rdy. flowid_ret_rdy never depends on
//     flowid_ret_val.
//
// Modports:
//   master : requester / teardown side
//   slave  : flow-ID manager side
// ---------------------------------------------------------------------------
interface tcp_flowid_manager_if #(
   parameter int FLOWID_W = 3
);
   logic                flowid_manager_req;
   logic                flowid_avail;
   logic [FLOWID_W-1:0] flowid_out;
   logic                flowid_ret_val;
   logic [FLOWID_W-1:0] flowid_ret_id;
   logic                flowid_ret_rdy;

   modport master (
      output flowid_manager_req,
      output flowid_ret_val,
      output flowid_ret_id,
      input  flowid_avail,
      input  flowid_out,
      input  flowid_ret_rdy
   );

   modport slave (
      input  flowid_manager_req,
      input  flowid_ret_val,
      input  flowid_ret_id,
      output flowid_avail,
      output flowid_out,
      output flowid_ret_rdy
   );
endinterface

// File: rtl/tcp_flowid_manager.sv
// ---------------------------------------------------------------------------
// tcp_flowid_manager
//
// Free-list allocator for TCP flow IDs. After reset the free list is filled
// with every ID (INIT), then IDs are popped by the new-flow FSM and pushed
// back by the teardown logic (RUN). An allocation bitmap rejects releases of
// IDs that are not currently allocated, so double or spurious frees cannot
// corrupt the list; such releases are consumed and flagged in err_bad_free.
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   rst          asynchronous, active-high reset
//   bus          allocate/release handshakes (slave modport)
//   num_free     number of IDs currently in the free list
//   init_done    free list fully populated after reset
//   err_bad_free sticky flag, release of an ID that was not allocated
//   dbg_state    current FSM state (0 = INIT, 1 = RUN)
// ---------------------------------------------------------------------------
module tcp_flowid_manager #(
   parameter int FLOWID_W = 3
) (
   input  logic                clk,
   input  logic                rst,
   tcp_flowid_manager_if.slave bus,
   output logic [FLOWID_W:0]   num_free,
   output logic                init_done,
   output logic                err_bad_free,
   output logic [0:0]          dbg_state
);

   localparam int                NUM_FLOWS = 1 << FLOWID_W;
   localparam logic [FLOWID_W:0] FULL_CNT  = (FLOWID_W + 1)'(NUM_FLOWS);
   localparam logic [FLOWID_W-1:0] LAST_IDX = FLOWID_W'(NUM_FLOWS - 1);

   localparam logic [0:0] ST_INIT = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   logic [0:0]          state;
   logic [FLOWID_W:0]   rd_ptr;
   logic [FLOWID_W:0]   wr_ptr;
   logic [FLOWID_W-1:0] init_cnt;
   logic [NUM_FLOWS-1:0] alloc_bitmap;
   logic [NUM_FLOWS-1:0] alloc_bitmap_next;
   logic [FLOWID_W-1:0] ram [NUM_FLOWS];

   logic                in_run;
   logic                list_empty;
   logic                list_full;
   logic                do_alloc;
   logic                ret_fire;
   logic                ret_known;
   logic                ret_good;
   logic                ret_bad;

   logic                ram_we;
   logic [FLOWID_W-1:0] ram_waddr;
   logic [FLOWID_W-1:0] ram_wdata;

   // ------------------------------------------------------------------
   // Status and handshake outputs. Only registered state feeds these, so
   // none of them depends combinationally on req or ret_val.
   // ------------------------------------------------------------------
   assign in_run     = (state == ST_RUN);
   // The pointers carry a wrap bit, so the modulo difference is the count
   // and full (NUM_FLOWS) is distinguishable from empty (0).
   assign num_free   = wr_ptr - rd_ptr;
   assign list_empty = (num_free == '0);
   assign list_full  = (num_free == FULL_CNT);

   assign bus.flowid_avail   = in_run & ~list_empty;
   assign bus.flowid_out     = ram[rd_ptr[FLOWID_W-1:0]];
   assign bus.flowid_ret_rdy = in_run & ~list_full;

   assign init_done = in_run;
   assign dbg_state = state;

   // ------------------------------------------------------------------
   // Transfer qualifiers
   // ------------------------------------------------------------------
   assign do_alloc  = bus.flowid_manager_req & bus.flowid_avail;
   assign ret_fire  = bus.flowid_ret_val & bus.flowid_ret_rdy;
   // Uses the pre-edge bitmap: releasing the ID being granted in the same
   // cycle sees it as not yet allocated and is rejected as a bad free.
   assign ret_known = alloc_bitmap[bus.flowid_ret_id];
   assign ret_good  = ret_fire & ret_known;
   assign ret_bad   = ret_fire & ~ret_known;

   // ------------------------------------------------------------------
   // Free-list RAM write port: INIT fills RAM[i] = i, RUN appends the
   // accepted released ID at the tail.
   // ------------------------------------------------------------------
   always_comb begin
      ram_we    = 1'b0;
      ram_waddr = '0;
      ram_wdata = '0;
      if (!in_run) begin
         ram_we    = 1'b1;
         ram_waddr = init_cnt;
         ram_wdata = init_cnt;
      end else if (ret_good) begin
         ram_we    = 1'b1;
         ram_waddr = wr_ptr[FLOWID_W-1:0];
         ram_wdata = bus.flowid_ret_id;
      end
   end

   // The RAM needs no reset: INIT rewrites every entry before it is read.
   always_ff @(posedge clk) begin
      if (ram_we) begin
         ram[ram_waddr] <= ram_wdata;
      end
   end

   // ------------------------------------------------------------------
   // Allocation bitmap update. A granted ID and an accepted released ID
   // are always different (an ID cannot be both free and allocated), so
   // the set and clear never collide.
   // ------------------------------------------------------------------
   always_comb begin
      alloc_bitmap_next = alloc_bitmap;
      if (do_alloc) begin
         alloc_bitmap_next[bus.flowid_out] = 1'b1;
      end
      if (ret_good) begin
         alloc_bitmap_next[bus.flowid_ret_id] = 1'b0;
      end
   end

   // ------------------------------------------------------------------
   // FSM, pointers, bitmap and error flag
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= ST_INIT;
         init_cnt     <= '0;
         rd_ptr       <= '0;
         wr_ptr       <= '0;
         alloc_bitmap <= '0;
         err_bad_free <= 1'b0;
      end else if (state == ST_INIT) begin
         init_cnt <= init_cnt + 1'b1;
         wr_ptr   <= wr_ptr + 1'b1;
         if (init_cnt == LAST_IDX) begin
            state <= ST_RUN;
         end
      end else begin
         if (do_alloc) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (ret_good) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         alloc_bitmap <= alloc_bitmap_next;
         if (ret_bad) begin
            err_bad_free <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_tcp_flowid_manager.sv
// ---------------------------------------------------------------------------
// tb_tcp_flowid_manager
//
// Directed and randomized checks of the flow-ID free list against a model
// holding the free list as a FIFO queue of IDs plus a set of allocated IDs.
// ---------------------------------------------------------------------------
module tb_tcp_flowid_manager;

   localparam int FLOWID_W = 3;
   localparam int NUM      = 1 << FLOWID_W;

   // ---------------- clock / reset ----------------
   logic clk;
   logic rst;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   tcp_flowid_manager_if #(.FLOWID_W(FLOWID_W)) bus ();

   logic [FLOWID_W:0] num_free;
   logic              init_done;
   logic              err_bad_free;
   logic [0:0]        dbg_state;

   tcp_flowid_manager #(.FLOWID_W(FLOWID_W)) dut (
      .clk          (clk),
      .rst          (rst),
      .bus          (bus.slave),
      .num_free     (num_free),
      .init_done    (init_done),
      .err_bad_free (err_bad_free),
      .dbg_state    (dbg_state)
   );

   // ---------------- reference model ----------------
   int free_q[$];       // free IDs, head is the next grant
   bit alloc_set [NUM]; // IDs currently held by users
   bit m_err;
   int init_left;       // INIT cycles still to run
   int got_q[$];        // IDs observed granted (for distinctness checks)

   int vectors;
   int miscompares;

   task automatic model_reset();
      free_q.delete();
      for (int i = 0; i < NUM; i++) alloc_set[i] = 1'b0;
      m_err     = 1'b0;
      init_left = NUM;
   endtask

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: inputs are already set; outputs are checked at the
   // falling edge, then the model advances as the rising edge will.
   task automatic tick();
      bit in_init, e_avail, e_rdy, g, r, good;
      int id, n;
      @(negedge clk);
      in_init = (init_left > 0);
      n       = free_q.size();
      e_avail = !in_init && (n > 0);
      e_rdy   = !in_init && (n != NUM);
      check("avail",     32'(bus.flowid_avail),   32'(e_avail));
      check("ret_rdy",   32'(bus.flowid_ret_rdy), 32'(e_rdy));
      check("num_free",  32'(num_free),           32'(n));
      check("init_done", 32'(init_done),          32'(!in_init));
      check("err",       32'(err_bad_free),       32'(m_err));
      if (e_avail) check("flowid_out", 32'(bus.flowid_out), 32'(free_q[0]));
      if (in_init) begin
         free_q.push_back(NUM - init_left);
         init_left--;
      end else begin
         g    = e_avail && bus.flowid_manager_req;
         r    = e_rdy && bus.flowid_ret_val;
         id   = int'(bus.flowid_ret_id);
         good = r && alloc_set[id];
         if (r && !alloc_set[id]) m_err = 1'b1;
         if (g) begin
            got_q.push_back(int'(bus.flowid_out));
            alloc_set[free_q[0]] = 1'b1;
            void'(free_q.pop_front());
         end
         if (good) begin
            free_q.push_back(id);
            alloc_set[id] = 1'b0;
         end
      end
      @(posedge clk);
      #1;
   endtask

   // ---------------- driver tasks ----------------
   task automatic drain(input int cycles);
      bus.flowid_manager_req = 1'b1;
      repeat (cycles) tick();
      bus.flowid_manager_req = 1'b0;
   endtask

   task automatic release_id(input int id);
      bus.flowid_ret_val = 1'b1;
      bus.flowid_ret_id  = FLOWID_W'(id);
      tick();
      bus.flowid_ret_val = 1'b0;
   endtask

   // Release every allocated ID in a random order.
   task automatic refill_shuffled();
      int ids[$];
      int j, t;
      for (int i = 0; i < NUM; i++) if (alloc_set[i]) ids.push_back(i);
      for (int i = ids.size() - 1; i > 0; i--) begin
         j      = $urandom_range(0, i);
         t      = ids[i];
         ids[i] = ids[j];
         ids[j] = t;
      end
      foreach (ids[k]) begin
         release_id(ids[k]);
         check("num_free_max", 32'(num_free <= NUM), 32'd1);
      end
   endtask

   task automatic check_distinct(input string tag, input int want);
      bit seen [NUM];
      int cnt;
      cnt = 0;
      for (int i = 0; i < NUM; i++) seen[i] = 1'b0;
      foreach (got_q[k]) begin
         if (!seen[got_q[k]]) cnt++;
         seen[got_q[k]] = 1'b1;
      end
      check(tag, 32'(cnt), 32'(want));
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_avail"},     32'(bus.flowid_avail),   32'd0);
      check({tag, "_ret_rdy"},   32'(bus.flowid_ret_rdy), 32'd0);
      check({tag, "_num_free"},  32'(num_free),           32'd0);
      check({tag, "_init_done"}, 32'(init_done),          32'd0);
      check({tag, "_err"},       32'(err_bad_free),       32'd0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      vectors     = 0;
      miscompares = 0;
      bus.flowid_manager_req = 1'b0;
      bus.flowid_ret_val     = 1'b0;
      bus.flowid_ret_id      = '0;
      rst = 1'b1;
      model_reset();
      #3;
      check_reset_outputs("por");
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      // Init: cycles 0..7 in INIT, cycle 8 shows the full list.
      repeat (NUM) tick();
      check("init_full", 32'(num_free), 32'(NUM));
      tick();

      // Drain: 9 requests, IDs 0..7 in order, 9th request is ignored.
      got_q.delete();
      drain(NUM + 1);
      for (int i = 0; i < NUM; i++) check("drain_order", 32'(got_q[i]), 32'(i));
      tick();

      // Release 5 then 2, then grant them back in that order.
      release_id(5);
      release_id(2);
      tick();
      got_q.delete();
      drain(2);
      check("regrant_5", 32'(got_q[0]), 32'd5);
      check("regrant_2", 32'(got_q[1]), 32'd2);
      tick();

      // Three full drain/refill rounds with shuffled release order.
      for (int round = 0; round < 3; round++) begin
         refill_shuffled();
         got_q.delete();
         drain(NUM);
         check_distinct("round_distinct", NUM);
      end

      // Simultaneous allocate and release of allocated ID 6 with 4 free.
      release_id(1);
      release_id(3);
      release_id(0);
      release_id(7);
      tick();
      bus.flowid_manager_req = 1'b1;
      bus.flowid_ret_val     = 1'b1;
      bus.flowid_ret_id      = FLOWID_W'(6);
      tick();
      bus.flowid_manager_req = 1'b0;
      bus.flowid_ret_val     = 1'b0;
      check("simul_count", 32'(num_free), 32'd4);
      got_q.delete();
      drain(4);
      check("simul_6_last", 32'(got_q[3]), 32'd6);

      // Bad free: 3 released twice, second release is rejected.
      release_id(3);
      release_id(3);
      check("bad_free_flag", 32'(err_bad_free), 32'd1);
      check("bad_free_count", 32'(num_free), 32'd1);
      refill_shuffled();
      got_q.delete();
      drain(NUM);
      check_distinct("post_bad_distinct", NUM);

      // Reset mid-run: allocate 3, then pulse rst between edges.
      refill_shuffled();
      drain(3);
      #1 rst = 1'b1;
      #1 check_reset_outputs("mid_rst");
      model_reset();
      #1 rst = 1'b0;
      repeat (NUM) tick();
      check("reinit_full", 32'(num_free), 32'(NUM));

      // Same ID allocated and released in one cycle counts as a bad free.
      drain(1);
      bus.flowid_manager_req = 1'b1;
      bus.flowid_ret_val     = 1'b1;
      bus.flowid_ret_id      = FLOWID_W'(1);
      tick();
      bus.flowid_manager_req = 1'b0;
      bus.flowid_ret_val     = 1'b0;
      check("same_id_err", 32'(err_bad_free), 32'd1);
      check("same_id_alloc", 32'(got_q[got_q.size() - 1]), 32'd1);
      tick();

      // Randomized traffic, mostly releasing held IDs, some spurious ones.
      for (int c = 0; c < 400; c++) begin
         int held[$];
         for (int i = 0; i < NUM; i++) if (alloc_set[i]) held.push_back(i);
         bus.flowid_manager_req = 1'($urandom_range(0, 1));
         bus.flowid_ret_val     = ($urandom_range(0, 2) != 0);
         if (held.size() > 0 && $urandom_range(0, 7) != 0)
            bus.flowid_ret_id = FLOWID_W'(held[$urandom_range(0, held.size() - 1)]);
         else
            bus.flowid_ret_id = FLOWID_W'($urandom_range(0, NUM - 1));
         tick();
      end
      bus.flowid_manager_req = 1'b0;
      bus.flowid_ret_val     = 1'b0;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
